// File: rtl/ecc_decode_pipe.sv
// Two-stage multi-lane SECDED decoder with valid/ready flow control,
// saturating error counters and a sticky first-uncorrectable-error log.
module ecc_decode_pipe #(
  parameter int LANES = 2,
  parameter int DW    = 64,
  parameter int PW    = $clog2(1 + DW + $clog2(1 + DW)),
  parameter int TAG_W = 8,
  parameter int CNT_W = 16,
  localparam int CW   = DW + PW + 1,
  localparam int LW   = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*CW-1:0]   in_data,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES*DW-1:0]   out_data,
  output logic [TAG_W-1:0]      out_tag,
  output logic [LANES-1:0]      out_sbiterr,
  output logic [LANES-1:0]      out_dbiterr,
  input  logic                  clr_cnt,
  output logic [CNT_W-1:0]      sbit_cnt,
  output logic [CNT_W-1:0]      dbit_cnt,
  output logic                  log_valid,
  output logic [TAG_W-1:0]      log_tag,
  output logic [LW-1:0]         log_lane,
  output logic [PW-1:0]         log_syndrome
);

  localparam int NP = DW + PW;

  typedef struct packed {
    logic                valid;
    logic [TAG_W-1:0]    tag;
    logic [LANES-1:0]    pmis;
    logic [LANES*PW-1:0] syn;
    logic [LANES*CW-1:0] cw;
  } s1_t;

  s1_t s1;
  logic [LANES*PW-1:0] s2_syn;
  logic adv, hs;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign hs       = out_valid & out_ready;

  logic [LANES*PW-1:0] syn_c;
  logic [LANES-1:0]    pmis_c;

  always_comb begin
    syn_c  = '0;
    pmis_c = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < NP; j++)
        for (int i = 0; i < PW; i++)
          if ((((j + 1) >> i) & 1) != 0)
            syn_c[k*PW+i] ^= in_data[k*CW+j];
      pmis_c[k] = ^in_data[k*CW +: CW];
    end
  end

  logic [LANES*DW-1:0] dat_c;
  logic [LANES-1:0]    sb_c, db_c;
  logic [NP-1:0]       fix;
  logic [PW-1:0]       syn;
  int                  d;

  always_comb begin
    dat_c = '0;
    sb_c  = '0;
    db_c  = '0;
    fix   = '0;
    syn   = '0;
    d     = 0;
    for (int k = 0; k < LANES; k++) begin
      fix = s1.cw[k*CW +: NP];
      syn = s1.syn[k*PW +: PW];
      if (s1.pmis[k]) begin
        if (syn == '0) begin
          sb_c[k] = 1'b1;
        end else if (int'(syn) <= NP) begin
          sb_c[k] = 1'b1;
          fix[syn-1] = ~fix[syn-1];
        end else begin
          db_c[k] = 1'b1;
        end
      end else if (syn != '0) begin
        db_c[k] = 1'b1;
      end
      // data sits at every non-power-of-two position, LSB first
      d = 0;
      for (int j = 0; j < NP; j++)
        if (((j + 1) & j) != 0) begin
          dat_c[k*DW+d] = fix[j];
          d++;
        end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1          <= '0;
      s2_syn      <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_sbiterr <= '0;
      out_dbiterr <= '0;
    end else if (adv) begin
      s1.valid    <= in_valid;
      s1.tag      <= in_tag;
      s1.pmis     <= pmis_c;
      s1.syn      <= syn_c;
      s1.cw       <= in_data;
      out_valid   <= s1.valid;
      out_data    <= dat_c;
      out_tag     <= s1.tag;
      out_sbiterr <= s1.valid ? sb_c : '0;
      out_dbiterr <= s1.valid ? db_c : '0;
      s2_syn      <= s1.syn;
    end
  end

  logic [CNT_W:0]   sb_sum, db_sum;
  logic [CNT_W-1:0] sb_sat, db_sat;
  logic [LW-1:0]    err_lane;
  logic [PW-1:0]    err_syn;

  always_comb begin
    sb_sum = {1'b0, sbit_cnt};
    db_sum = {1'b0, dbit_cnt};
    for (int k = 0; k < LANES; k++) begin
      sb_sum += (CNT_W+1)'(out_sbiterr[k]);
      db_sum += (CNT_W+1)'(out_dbiterr[k]);
    end
    sb_sat = sb_sum[CNT_W] ? '1 : sb_sum[CNT_W-1:0];
    db_sat = db_sum[CNT_W] ? '1 : db_sum[CNT_W-1:0];
  end

  always_comb begin
    err_lane = '0;
    err_syn  = '0;
    for (int k = LANES - 1; k >= 0; k--)
      if (out_dbiterr[k]) begin
        err_lane = LW'(k);
        err_syn  = s2_syn[k*PW +: PW];
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sbit_cnt     <= '0;
      dbit_cnt     <= '0;
      log_valid    <= 1'b0;
      log_tag      <= '0;
      log_lane     <= '0;
      log_syndrome <= '0;
    end else if (clr_cnt) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      log_valid <= 1'b0;
    end else if (hs) begin
      sbit_cnt <= sb_sat;
      dbit_cnt <= db_sat;
      if (!log_valid && |out_dbiterr) begin
        log_valid    <= 1'b1;
        log_tag      <= out_tag;
        log_lane     <= err_lane;
        log_syndrome <= err_syn;
      end
    end
  end

endmodule

// File: tb/tb_ecc_decode_pipe.sv
// Scoreboard bench for ecc_decode_pipe: random and directed beats checked
// against a position-XOR Hamming reference model.
module tb_ecc_decode_pipe;

  localparam int LANES = 2;
  localparam int DW    = 64;
  localparam int PW    = 7;
  localparam int TAG_W = 8;
  localparam int CNT_W = 4;
  localparam int CW    = DW + PW + 1;
  localparam int NP    = DW + PW;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid, in_ready;
  logic [LANES*CW-1:0] in_data;
  logic [TAG_W-1:0]    in_tag;
  logic                out_valid, out_ready;
  logic [LANES*DW-1:0] out_data;
  logic [TAG_W-1:0]    out_tag;
  logic [LANES-1:0]    out_sbiterr, out_dbiterr;
  logic                clr_cnt;
  logic [CNT_W-1:0]    sbit_cnt, dbit_cnt;
  logic                log_valid;
  logic [TAG_W-1:0]    log_tag;
  logic [0:0]          log_lane;
  logic [PW-1:0]       log_syndrome;

  ecc_decode_pipe #(
    .LANES(LANES), .DW(DW), .TAG_W(TAG_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag),
    .out_sbiterr(out_sbiterr), .out_dbiterr(out_dbiterr),
    .clr_cnt(clr_cnt),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt),
    .log_valid(log_valid), .log_tag(log_tag),
    .log_lane(log_lane), .log_syndrome(log_syndrome)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [LANES*DW-1:0] data;
    logic [LANES-1:0]    sb;
    logic [LANES-1:0]    db;
    logic [LANES*PW-1:0] syn;
    logic [TAG_W-1:0]    tag;
    int                  acc;
    bit                  exact;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] encode(input logic [DW-1:0] d);
    logic [CW-1:0] c;
    int s, k;
    c = '0; s = 0; k = 0;
    for (int pos = 1; pos <= NP; pos++)
      if ((pos & (pos - 1)) != 0) begin
        c[pos-1] = d[k];
        if (d[k]) s ^= pos;
        k++;
      end
    for (int i = 0; i < PW; i++) c[(1 << i) - 1] = s[i];
    c[CW-1] = ^c[CW-2:0];
    return c;
  endfunction

  function automatic void model_dec(input logic [CW-1:0] c,
    output logic [DW-1:0] d, output logic sb, output logic db,
    output logic [PW-1:0] syn);
    int s, k;
    logic [CW-1:0] cc;
    s = 0; k = 0; cc = c; sb = 0; db = 0; d = '0;
    for (int pos = 1; pos <= NP; pos++)
      if (c[pos-1]) s ^= pos;
    if (^c) begin
      if (s == 0) sb = 1;
      else if (s <= NP) begin sb = 1; cc[s-1] = ~cc[s-1]; end
      else db = 1;
    end else if (s != 0) db = 1;
    for (int pos = 1; pos <= NP; pos++)
      if ((pos & (pos - 1)) != 0) begin
        d[k] = cc[pos-1];
        k++;
      end
    syn = PW'(s);
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [CW-1:0] corrupt(input logic [CW-1:0] c);
    int kind, b1, b2, b3;
    logic [CW-1:0] r;
    r = c;
    kind = $urandom_range(0, 9);
    b1 = $urandom_range(0, CW - 1);
    b2 = (b1 + 1 + $urandom_range(0, CW - 2)) % CW;
    b3 = b1;
    while (b3 == b1 || b3 == b2) b3 = $urandom_range(0, CW - 1);
    if (kind >= 4) r[b1] = ~r[b1];
    if (kind >= 7) r[b2] = ~r[b2];
    if (kind == 9) r[b3] = ~r[b3];
    return r;
  endfunction

  task automatic send(input logic [CW-1:0] c0, input logic [CW-1:0] c1,
                      input logic [TAG_W-1:0] tag, input bit exact);
    exp_t e;
    logic [DW-1:0] d;
    logic s, b;
    logic [PW-1:0] y;
    int w;
    bit ok;
    model_dec(c0, d, s, b, y);
    e.data[DW-1:0] = d; e.sb[0] = s; e.db[0] = b; e.syn[PW-1:0] = y;
    model_dec(c1, d, s, b, y);
    e.data[2*DW-1:DW] = d; e.sb[1] = s; e.db[1] = b;
    e.syn[2*PW-1:PW] = y;
    e.tag = tag; e.exact = exact;
    in_data = {c1, c0}; in_tag = tag; in_valid = 1'b1;
    w = 0; ok = 0;
    while (!ok && w < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1;
      w++;
    end
    if (!ok) begin
      chk("in_ready_timeout", 0, 1);
    end else begin
      e.acc = cyc + 1;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      @(posedge clk);
      w++;
    end
    #1;
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
  endtask

  // monitor: pops the scoreboard on each output handshake and tracks
  // the expected counter/log state
  int m_sb = 0, m_db = 0, m_ll = 0, lat = 0;
  bit m_lv = 0, stalled = 0, hs;
  logic [TAG_W-1:0] m_lt = '0;
  logic [PW-1:0] m_ls = '0;
  logic [LANES*DW-1:0] held_d;
  logic [TAG_W-1:0] held_t;
  exp_t me;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_sb = 0; m_db = 0; m_lv = 0; stalled = 0;
    end else begin
      chk("sbit_cnt", sbit_cnt, m_sb);
      chk("dbit_cnt", dbit_cnt, m_db);
      chk("log_valid", log_valid, m_lv);
      if (m_lv) begin
        chk("log_tag", log_tag, m_lt);
        chk("log_lane", log_lane, m_ll);
        chk("log_syndrome", log_syndrome, m_ls);
      end
      if (stalled) begin
        chk("stall_data", out_data, held_d);
        chk("stall_tag", out_tag, held_t);
      end
      stalled = out_valid && !out_ready;
      if (stalled) begin
        held_d = out_data;
        held_t = out_tag;
        chk("in_ready_stall", in_ready, 0);
      end
      hs = 0;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          hs = 1;
          me = sb_q.pop_front();
          chk("out_data", out_data, me.data);
          chk("out_tag", out_tag, me.tag);
          chk("out_sbiterr", out_sbiterr, me.sb);
          chk("out_dbiterr", out_dbiterr, me.db);
          lat = cyc + 1 - me.acc;
          if (me.exact) chk("latency", lat, 2);
          else chk("latency_min", lat >= 2, 1);
        end
      end
      if (clr_cnt) begin
        m_sb = 0; m_db = 0; m_lv = 0;
      end else if (hs) begin
        m_sb = m_sb + $countones(me.sb);
        m_db = m_db + $countones(me.db);
        if (m_sb > CMAX) m_sb = CMAX;
        if (m_db > CMAX) m_db = CMAX;
        if (!m_lv && me.db != 0) begin
          m_lv = 1;
          m_lt = me.tag;
          m_ll = me.db[0] ? 0 : 1;
          m_ls = me.db[0] ? me.syn[PW-1:0] : me.syn[2*PW-1:PW];
        end
      end
    end
  end

  logic [CW-1:0] c0, c1;
  bit rnd_done;
  int w;

  initial begin
    rst = 1; in_valid = 0; in_data = '0; in_tag = '0;
    out_ready = 1; clr_cnt = 0; rnd_done = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_sbiterr, out_dbiterr}, 0);
    chk("rst_cnts", {sbit_cnt, dbit_cnt}, 0);
    chk("rst_log", {log_valid, log_tag}, 0);

    send(encode(64'h0123456789ABCDEF), encode(64'h0), 8'h11, 1);
    drain();
    chk("clean_cnt", {sbit_cnt, dbit_cnt}, 0);

    c0 = encode(64'hDEADBEEFCAFEF00D);
    c0[2] = ~c0[2];
    send(c0, encode(64'h0), 8'h12, 1);
    drain();
    chk("single_sbit_cnt", sbit_cnt, 1);

    c1 = encode(64'h0);
    c1[71] = ~c1[71];
    send(encode(64'h5555AAAA5555AAAA), c1, 8'h13, 1);
    drain();
    chk("opar_sbit_cnt", sbit_cnt, 2);
    chk("opar_dbit_cnt", dbit_cnt, 0);

    c1 = encode(64'h00FF00FF12345678);
    c1[2] = ~c1[2]; c1[5] = ~c1[5];
    send(encode(64'h1), c1, 8'h05, 1);
    drain();
    chk("dbl_log_valid", log_valid, 1);
    chk("dbl_log_tag", log_tag, 8'h05);
    chk("dbl_log_lane", log_lane, 1);
    chk("dbl_log_syn", log_syndrome, 5);

    c0 = encode(64'hFFFF0000FFFF0000);
    c0[10] = ~c0[10]; c0[40] = ~c0[40];
    send(c0, encode(64'h2), 8'h09, 1);
    drain();
    chk("dbl2_log_tag", log_tag, 8'h05);
    chk("dbl2_dbit_cnt", dbit_cnt, 2);

    fork
      for (int t = 0; t < 10; t++)
        send(encode(rnd64()), encode(rnd64()), TAG_W'(t), 0);
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();

    fork
      begin
        for (int t = 0; t < 300; t++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(corrupt(encode(rnd64())), corrupt(encode(rnd64())),
               TAG_W'($urandom), 0);
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = $urandom_range(0, 2) != 0;
        end
        out_ready = 1;
      end
    join
    drain();

    clr_cnt = 1;
    @(posedge clk); #1;
    clr_cnt = 0;
    chk("clr_sbit", sbit_cnt, 0);
    chk("clr_log", log_valid, 0);
    for (int t = 0; t < 20; t++) begin
      c0 = encode(rnd64());
      c0[$urandom_range(0, CW - 1)] ^= 1'b1;
      send(c0, encode(rnd64()), TAG_W'(t), 0);
    end
    drain();
    chk("sat_sbit", sbit_cnt, CMAX);

    out_ready = 0;
    c0 = encode(rnd64());
    c0[3] = ~c0[3]; c0[7] = ~c0[7];
    c1 = encode(rnd64());
    c1[0] = ~c1[0];
    send(c0, c1, 8'h21, 0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("hold_out_valid", out_valid, 1);
    clr_cnt = 1; out_ready = 1;
    @(posedge clk); #1;
    clr_cnt = 0;
    chk("clrhs_cnts", {sbit_cnt, dbit_cnt}, 0);
    chk("clrhs_log", log_valid, 0);
    drain();

    send(encode(rnd64()), encode(rnd64()), 8'h31, 0);
    send(encode(rnd64()), encode(rnd64()), 8'h32, 0);
    rst = 1;
    sb_q.delete();
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("midrst_in_ready", in_ready, 1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_stale", out_valid, 0);
    chk("midrst_cnts", {sbit_cnt, dbit_cnt, log_valid}, 0);

    chk("queue_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ecc_decode_pipe.md
Name: ecc_decode_pipe

Overview:
Multi-lane, pipelined SECDED Hamming decoder with a valid/ready stream interface. It sits between the on-chip SRAM/FIFO read ports and their consumers. Each beat carries LANES independent codewords and an opaque tag. The block corrects single-bit errors, flags double-bit errors, keeps saturating error counters, and logs the first uncorrectable error for software.

Parameters:
- LANES, 2, codewords per beat.
- DW, 64, data bits per lane.
- PW, $clog2(1+DW+$clog2(1+DW)), Hamming parity bits per lane (7 for DW=64).
- TAG_W, 8, width of sideband tag (e.g. SRAM address) carried with each beat.
- CNT_W, 16, error counter width.
- Derived: CW = DW+PW+1 (codeword width); LW = max(1, $clog2(LANES)).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- in_data  in  LANES*CW  codewords; lane k occupies bits [k*CW +: CW].
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_data  out  LANES*DW  decoded data; lane k occupies bits [k*DW +: DW].
- out_tag  out  TAG_W  tag of the output beat.
- out_sbiterr  out  LANES  per lane: corrected single error.
- out_dbiterr  out  LANES  per lane: uncorrectable error.
- clr_cnt  in  1  synchronous clear of counters and log.
- sbit_cnt  out  CNT_W  corrected-error count (lanes summed).
- dbit_cnt  out  CNT_W  uncorrectable-error count (lanes summed).
- log_valid  out  1  sticky; first dbit error captured.
- log_tag  out  TAG_W  tag of the logged error.
- log_lane  out  LW  lane of the logged error.
- log_syndrome  out  PW  syndrome of the logged error.

Behaviour:
- Codeword layout per lane:
  - bits [DW+PW-1:0] are Hamming positions 1..DW+PW; bit j is position j+1.
  - Positions that are powers of two are parity bits; all other positions hold data, LSB first.
  - Bit CW-1 is the overall parity (even over the whole codeword).
- Stage 1 registers, per lane:
  - syndrome[i] = XOR of bits j where ((j+1) & 2^i) != 0.
  - pmis = XOR of all CW bits.
  - The raw codeword.
  - Tag and valid are registered with the stage.
- Stage 2 registers corrected/extracted data, flags, tag and valid.
- Latency is exactly 2 cycles from input handshake to out_valid when there is no stall.
- Pipeline control:
  - adv = ~s2_valid | out_ready; in_ready = adv.
  - When adv=1, s1 moves to s2 and input moves to s1.
  - When adv=0, both stages hold; out_* is stable while out_valid & ~out_ready.
  - No beat is lost, duplicated or reordered.
- Classification per lane:
  - syn=0, pmis=0: clean.
  - syn!=0, pmis=1, syn<=DW+PW: flip bit syn-1, sbiterr=1.
  - syn=0, pmis=1: overall parity bit error; data unchanged, sbiterr=1.
  - syn!=0, pmis=0: dbiterr=1, data passed uncorrected.
  - syn>DW+PW, pmis=1: dbiterr=1, no correction.
  - sbiterr and dbiterr are never both 1 on a lane.
- Counters:
  - Updated on the output handshake: sbit_cnt += popcount(out_sbiterr); dbit_cnt += popcount(out_dbiterr).
  - Counters saturate at 2^CNT_W-1.
  - clr_cnt zeroes both counters and log_valid; clear wins over a simultaneous increment or capture.
- Log:
  - On an output handshake with any dbiterr while log_valid=0, capture log_tag, the lowest-indexed erring lane, and its syndrome; set log_valid.
  - Later errors do not overwrite the log until clr_cnt.
- Reset (async, any time, including mid-stream):
  - s1/s2 valid=0, out_valid=0.
  - All data/flag/tag/log outputs 0, counters 0, log_valid=0.
  - In-flight beats are discarded.
  - in_ready=1 on the first cycle after reset deasserts.

Test Plan:
- Clean beat (LANES=2, DW=64): lane0 = encode(0x0123456789ABCDEF), lane1 = encode(0), tag 0x11 -> out_valid exactly 2 cycles later; data exact; flags 0; counters 0.
- Single data error: flip in_data bit 2 (position 3, d1) of lane0 -> lane0 data corrected; out_sbiterr=2'b01; sbit_cnt=1.
- Overall-parity error: flip bit 71 of lane1 -> data unchanged; out_sbiterr=2'b10; dbit flags 0; sbit_cnt increments.
- Double error: flip bits 2 and 5 of lane1, tag 0x05 -> out_dbiterr=2'b10; log_valid=1, log_tag=0x05, log_lane=1, log_syndrome=5. A later dbit beat with tag 0x09 leaves the log unchanged; dbit_cnt=2.
- Backpressure: stream 10 beats (tags 0..9) with out_ready low for cycles 3-7 -> in_ready low while stalled; all 10 beats emerge in order, none lost or duplicated; out_data stable during the stall.
- Saturation/clear/reset (CNT_W=4):
  - 20 single-error beats -> sbit_cnt=15.
  - clr_cnt asserted in the same cycle as an erring handshake -> counters 0, log_valid 0.
  - rst asserted with 2 beats in flight -> out_valid=0 immediately; no stale beat emerges after release.
